// File: rtl/acc_pkg.sv
// Shared types and helpers for the MAC accumulator stage.
// sat_add is only referenced when ACC_SAT_EN is defined.
package acc_pkg;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } acc_state_t;

    // Operands arrive already sign/zero-extended to 64 bits; result is clamped to a width-bit range
    function automatic logic [63:0] sat_add(
        input logic [63:0]  a,
        input logic [63:0]  b,
        input logic         signed_mode,
        input int unsigned  width
    );
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s = $signed(a + b);
        if (signed_mode) begin
            hi = (64'sd1 <<< (width - 1)) - 64'sd1;
            lo = -(64'sd1 <<< (width - 1));
        end else begin
            hi = (64'sd1 <<< width) - 64'sd1;
            lo = 64'sd0;
        end
        if (s > hi) begin
            return hi;
        end
        if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/dti_s_if.sv
// Valid/ready streaming interface with an end-of-transfer marker.
interface dti_s_if #(
    parameter int unsigned W = 16
) ();
    logic [W-1:0] data;
    logic         dvalid;
    logic         dready;
    logic         eot;

    modport producer (output data, output dvalid, output eot, input dready);
    modport consumer (input data, input dvalid, input eot, output dready);
endinterface

// File: rtl/acc_cnt.sv
// Beat counter for one accumulation group: terminal-count flag at ACC_LEN-1, sync clear.
module acc_cnt #(
    parameter int unsigned ACC_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic tc_c
);
    localparam int unsigned CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;

    logic [CW-1:0] cnt;

    // clr wins over inc: the last beat of a group returns the count to zero
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tc_c = (cnt == CW'(ACC_LEN - 1));

endmodule

// File: rtl/acc.sv
// Accumulator stage after the multiplier: sums ACC_LEN products (or fewer on din.eot) into one dout beat.
// Define ACC_SAT_EN to clamp each addition to the dout range instead of wrapping.
module acc
    import acc_pkg::*;
#(
    parameter int unsigned TDIN       = 16,
    parameter int unsigned ACC_LEN    = 4,
    parameter int unsigned DIN_SIGNED = 0,
    parameter int unsigned TDOUT      = TDIN + $clog2(ACC_LEN)
) (
    input  logic        clk,
    input  logic        rst,
    dti_s_if.consumer   din,
    dti_s_if.producer   dout
);
    acc_state_t         state_q;
    acc_state_t         state_d;
    logic [TDOUT-1:0]   acc_q;
    logic [TDOUT-1:0]   acc_d;
    logic [TDOUT-1:0]   res_q;
    logic [TDOUT-1:0]   res_d;
    logic               eot_q;
    logic               eot_d;

    logic [TDIN-1:0]    din_data_c;
    logic [TDOUT-1:0]   base_c;
    logic [63:0]        base_x_c;
    logic [63:0]        din_x_c;
    logic [TDOUT-1:0]   nxt_c;
    logic               din_hs_c;
    logic               dout_hs_c;
    logic               tc_c;
    logic               last_c;

    assign din_data_c = din.data;
    assign din_hs_c   = din.dvalid && din.dready;
    assign dout_hs_c  = dout.dvalid && dout.dready;
    assign last_c     = tc_c || din.eot;

    // A beat taken while releasing a result starts a fresh group, so it adds to zero
    assign base_c = (state_q == ACC) ? acc_q : '0;

    if (DIN_SIGNED != 0) begin : g_sext
        assign din_x_c  = 64'($signed(din_data_c));
        assign base_x_c = 64'($signed(base_c));
    end else begin : g_zext
        assign din_x_c  = 64'(din_data_c);
        assign base_x_c = 64'(base_c);
    end

`ifdef ACC_SAT_EN
    assign nxt_c = TDOUT'(sat_add(base_x_c, din_x_c, DIN_SIGNED != 0, TDOUT));
`else
    assign nxt_c = TDOUT'(base_x_c + din_x_c);
`endif

    acc_cnt #(
        .ACC_LEN (ACC_LEN)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (din_hs_c),
        .clr  (din_hs_c && last_c),
        .tc_c (tc_c)
    );

    // In OUT, din is only accepted together with the release of the held result
    assign din.dready  = (state_q == ACC) ? 1'b1 : dout.dready;
    assign dout.dvalid = (state_q == OUT);
    assign dout.data   = res_q;
    assign dout.eot    = eot_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACC;
            acc_q   <= '0;
            res_q   <= '0;
            eot_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            eot_q   <= eot_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        res_d   = res_q;
        eot_d   = eot_q;
        case (state_q)
            ACC: begin
                if (din_hs_c) begin
                    acc_d = nxt_c;
                    if (last_c) begin
                        res_d   = nxt_c;
                        eot_d   = din.eot;
                        state_d = OUT;
                    end
                end
            end
            OUT: begin
                if (dout_hs_c) begin
                    if (din_hs_c) begin
                        acc_d = nxt_c;
                        // A single-beat group reloads the result and stays in OUT
                        if (last_c) begin
                            res_d = nxt_c;
                            eot_d = din.eot;
                        end else begin
                            state_d = ACC;
                        end
                    end else begin
                        acc_d   = '0;
                        state_d = ACC;
                    end
                end
            end
            default: state_d = ACC;
        endcase
    end

endmodule

// File: tb/tb_acc.sv
// Scoreboard bench for acc: three instances (unsigned 16-bit, signed 8-bit, narrow 8-bit out).
module tb_acc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  dv;
    logic [2:0]  de;
    logic [2:0]  ordy;
    logic [2:0]  irdy;
    logic [15:0] dd [3];

    int n_cmp = 0;
    int n_err = 0;

    // Expected dout beats: {eot, data}
    logic [32:0] q0[$];
    logic [32:0] q1[$];
    logic [32:0] q2[$];

    dti_s_if #(.W(16)) i0 ();
    dti_s_if #(.W(18)) o0 ();
    dti_s_if #(.W(8))  i1 ();
    dti_s_if #(.W(10)) o1 ();
    dti_s_if #(.W(8))  i2 ();
    dti_s_if #(.W(8))  o2 ();

    assign i0.dvalid = dv[0];
    assign i0.data   = dd[0];
    assign i0.eot    = de[0];
    assign o0.dready = ordy[0];
    assign i1.dvalid = dv[1];
    assign i1.data   = dd[1][7:0];
    assign i1.eot    = de[1];
    assign o1.dready = ordy[1];
    assign i2.dvalid = dv[2];
    assign i2.data   = dd[2][7:0];
    assign i2.eot    = de[2];
    assign o2.dready = ordy[2];
    assign irdy      = {i2.dready, i1.dready, i0.dready};

    acc #(.TDIN(16), .ACC_LEN(4), .DIN_SIGNED(0), .TDOUT(18)) u0 (
        .clk(clk), .rst(rst), .din(i0), .dout(o0));
    acc #(.TDIN(8), .ACC_LEN(4), .DIN_SIGNED(1), .TDOUT(10)) u1 (
        .clk(clk), .rst(rst), .din(i1), .dout(o1));
    acc #(.TDIN(8), .ACC_LEN(4), .DIN_SIGNED(0), .TDOUT(8)) u2 (
        .clk(clk), .rst(rst), .din(i2), .dout(o2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic pop_chk(input int k, input logic [31:0] act, input logic ae);
        logic [32:0] e;
        int sz;
        sz = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
        if (sz == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL dout%0d_unexpected: got beat 0x%0h, required no beat", k, act);
            return;
        end
        case (k)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
        chk($sformatf("dout%0d_data", k), act, e[31:0]);
        chk($sformatf("dout%0d_eot", k), 32'(ae), 32'(e[32]));
    endtask

    // Called at a negedge; returns at the negedge following the accepting posedge
    task automatic send(input int k, input logic [15:0] d, input logic e);
        bit hs;
        hs    = 1'b0;
        dv[k] = 1'b1;
        dd[k] = d;
        de[k] = e;
        for (int n = 0; n < 50 && !hs; n++) begin
            #1 hs = irdy[k];
            @(negedge clk);
        end
        dv[k] = 1'b0;
        de[k] = 1'b0;
        if (!hs) begin
            n_cmp++;
            n_err++;
            $display("FAIL din%0d_accept: got no handshake in 50 cycles, required acceptance", k);
        end
    endtask

    // Monitors: a dout handshake will occur at the next posedge when dvalid && dready
    always @(negedge clk) begin
        #2;
        if (!rst && o0.dvalid && ordy[0]) pop_chk(0, 32'(o0.data), o0.eot);
    end
    always @(negedge clk) begin
        #2;
        if (!rst && o1.dvalid && ordy[1]) pop_chk(1, 32'(o1.data), o1.eot);
    end
    always @(negedge clk) begin
        #2;
        if (!rst && o2.dvalid && ordy[2]) pop_chk(2, 32'(o2.data), o2.eot);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        dv   = '0;
        de   = '0;
        ordy = '1;
        for (int i = 0; i < 3; i++) dd[i] = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_dvalid0", 32'(o0.dvalid), 32'd0);
        chk("rst_dready0", 32'(i0.dready), 32'd1);
        chk("rst_data0",   32'(o0.data),   32'd0);
        chk("rst_eot0",    32'(o0.eot),    32'd0);
        chk("rst_dvalid1", 32'(o1.dvalid), 32'd0);
        chk("rst_dvalid2", 32'(o2.dvalid), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Full group, back-to-back; result visible right after the 4th accept
        q0.push_back({1'b0, 32'd24});
        send(0, 16'd3, 1'b0);
        send(0, 16'd5, 1'b0);
        send(0, 16'd7, 1'b0);
        send(0, 16'd9, 1'b0);
        #1 chk("latency_dvalid0", 32'(o0.dvalid), 32'd1);

        // Early eot, then a fresh group starting from zero, then 1-beat groups in OUT
        q0.push_back({1'b1, 32'd30});
        send(0, 16'd10, 1'b0);
        send(0, 16'd20, 1'b1);
        q0.push_back({1'b0, 32'd10});
        send(0, 16'd1, 1'b0);
        send(0, 16'd2, 1'b0);
        send(0, 16'd3, 1'b0);
        send(0, 16'd4, 1'b0);
        q0.push_back({1'b1, 32'd7});
        q0.push_back({1'b1, 32'd8});
        q0.push_back({1'b1, 32'd9});
        send(0, 16'd7, 1'b1);
        send(0, 16'd8, 1'b1);
        send(0, 16'd9, 1'b1);
        @(negedge clk);

        // Backpressure: result held, din stalled, nothing lost or duplicated
        ordy[0] = 1'b0;
        q0.push_back({1'b0, 32'd10});
        q0.push_back({1'b0, 32'd26});
        send(0, 16'd1, 1'b0);
        send(0, 16'd2, 1'b0);
        send(0, 16'd3, 1'b0);
        send(0, 16'd4, 1'b0);
        fork
            begin
                send(0, 16'd5, 1'b0);
                send(0, 16'd6, 1'b0);
                send(0, 16'd7, 1'b0);
                send(0, 16'd8, 1'b0);
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    #1;
                    chk("stall_din_dready0", 32'(i0.dready), 32'd0);
                    chk("stall_dout_data0",  32'(o0.data),   32'd10);
                    @(negedge clk);
                end
                ordy[0] = 1'b1;
            end
        join

        // Signed: -128 + -128 + 127 + 1 = -128, 10-bit pattern 0x380
        q1.push_back({1'b0, 32'h380});
        send(1, 16'h0080, 1'b0);
        send(1, 16'h0080, 1'b0);
        send(1, 16'h007F, 1'b0);
        send(1, 16'h0001, 1'b0);

        // Narrow output: 200 + 100 overflows 8 bits
`ifdef ACC_SAT_EN
        q2.push_back({1'b1, 32'd255});
`else
        q2.push_back({1'b1, 32'd44});
`endif
        send(2, 16'd200, 1'b0);
        send(2, 16'd100, 1'b1);
        q2.push_back({1'b0, 32'd100});
        send(2, 16'd10, 1'b0);
        send(2, 16'd20, 1'b0);
        send(2, 16'd30, 1'b0);
        send(2, 16'd40, 1'b0);
        repeat (2) @(negedge clk);

        // Reset mid-group discards the partial sum
        send(0, 16'd1, 1'b0);
        send(0, 16'd2, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_dvalid0", 32'(o0.dvalid), 32'd0);
        chk("midrst_dready0", 32'(i0.dready), 32'd1);
        chk("midrst_data0",   32'(o0.data),   32'd0);
        @(negedge clk);
        q0.push_back({1'b0, 32'd4});
        send(0, 16'd1, 1'b0);
        send(0, 16'd1, 1'b0);
        send(0, 16'd1, 1'b0);
        send(0, 16'd1, 1'b0);

        for (int n = 0; n < 20 && (q0.size() + q1.size() + q2.size()) != 0; n++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("drain_pending", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
